// File: rtl/mem_access_stage.sv
// Memory stage of the five-stage MIPS pipeline: turns EX/MEM memory controls
// into a ready/req data-memory transaction, steers store lanes, extracts and
// extends load data, stalls on slow memory and registers the MEM/WB outputs.
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              inicio,
  input  logic [1:0]        MemReadM,
  input  logic              LoadUnsignedM,
  input  logic [3:0]        MemWriteM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [31:0]       WriteDataM,
  input  logic [4:0]        WriteRegM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ready,
  output logic              StallM,
  output logic              MisalignM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [31:0]       ReadDataW,
  output logic [ADDR_W-1:0] ALUOutW,
  output logic [4:0]        WriteRegW
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_nxt;

  logic       ld, st, op, acc_half, acc_word, misalign, go;
  logic [1:0] sh;
  logic [3:0] size_mask;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext, rd_nxt;

  // Decode access size; a store overrides a simultaneously encoded load.
  always_comb begin
    ld        = |MemReadM;
    st        = |MemWriteM;
    op        = ld | st;
    sh        = ALUOutM[1:0];
    acc_half  = st ? (MemWriteM == 4'b0011) : (MemReadM == 2'b10);
    acc_word  = st ? (MemWriteM == 4'b1111) : (MemReadM == 2'b11);
    misalign  = op & ((acc_half & sh[0]) | (acc_word & (sh != 2'b00)));
    go        = inicio & op & ~misalign;
    size_mask = 4'b0000;
    if (st)                       size_mask = MemWriteM;
    else if (MemReadM == 2'b01)   size_mask = 4'b0001;
    else if (MemReadM == 2'b10)   size_mask = 4'b0011;
    else if (MemReadM == 2'b11)   size_mask = 4'b1111;
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    byte_sel = dmem_rdata[{sh, 3'b000} +: 8];
    half_sel = dmem_rdata[{sh[1], 4'b0000} +: 16];
    case (MemReadM)
      2'b01:   ld_ext = {{24{~LoadUnsignedM & byte_sel[7]}}, byte_sel};
      2'b10:   ld_ext = {{16{~LoadUnsignedM & half_sel[15]}}, half_sel};
      2'b11:   ld_ext = dmem_rdata;
      default: ld_ext = 32'h0;
    endcase
    // Stores and misaligned accesses carry no load data into WB.
    rd_nxt = (ld & ~st & ~misalign) ? ld_ext : 32'h0;
  end

  // FSM state register; reset aborts any outstanding transaction.
  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM next state: wait while an issued access has not completed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (go && !dmem_ready) state_nxt = S_WAIT;
      S_WAIT: if (dmem_ready || !inicio) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: bus drive and stall; all bus fields zero without a request.
  always_comb begin
    dmem_req = 1'b0;
    case (state)
      S_IDLE:  dmem_req = go;
      // EX/MEM is frozen, so the aligned op that entered WAIT is still there.
      S_WAIT:  dmem_req = inicio;
      default: dmem_req = 1'b0;
    endcase
    StallM     = dmem_req & ~dmem_ready;
    dmem_we    = dmem_req & st;
    dmem_addr  = dmem_req ? {ALUOutM[ADDR_W-1:2], 2'b00} : '0;
    dmem_be    = dmem_req ? (size_mask << sh) : 4'b0000;
    dmem_wdata = 32'h0;
    if (dmem_req && st) begin
      if (MemWriteM == 4'b1111)      dmem_wdata = WriteDataM;
      else if (MemWriteM == 4'b0011) dmem_wdata = {2{WriteDataM[15:0]}};
      else                           dmem_wdata = {4{WriteDataM[7:0]}};
    end
  end

  // MEM/WB registers: advance when not stalled, otherwise insert a bubble.
  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= 32'h0;
      ALUOutW   <= '0;
      WriteRegW <= 5'd0;
      MisalignM <= 1'b0;
    end else begin
      MisalignM <= misalign;
      if (StallM) begin
        RegWriteW <= 1'b0;
      end else begin
        RegWriteW <= RegWriteM & ~misalign;
        MemtoRegW <= MemtoRegM;
        ReadDataW <= rd_nxt;
        ALUOutW   <= ALUOutM;
        WriteRegW <= WriteRegM;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, hand-written
// stall/reset sequences, and randomized traffic against a behavioural model.
module tb_mem_access_stage;

  logic        clk;
  logic        inicio;
  logic [1:0]  MemReadM;
  logic        LoadUnsignedM;
  logic [3:0]  MemWriteM;
  logic        RegWriteM, MemtoRegM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        StallM, MisalignM, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .inicio(inicio),
    .MemReadM(MemReadM), .LoadUnsignedM(LoadUnsignedM), .MemWriteM(MemWriteM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .StallM(StallM), .MisalignM(MisalignM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected finish before 500000");
    $fatal(1);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  logic        e_rw, e_mtr, e_mis;
  logic [31:0] e_rdw, e_alu;
  logic [4:0]  e_wr;

  task automatic model_comb(output logic req, output logic we, output logic [3:0] be,
                            output logic [31:0] addr, output logic [31:0] wdata,
                            output logic stall, output logic mis, output logic [31:0] rdw);
    int size, off, be_i;
    bit store, load, op;
    logic [63:0] v, mask;
    store = (MemWriteM != 0);
    load  = (MemReadM != 0);
    op    = store || load;
    if (store) size = (MemWriteM == 4'b1111) ? 4 : (MemWriteM == 4'b0011) ? 2 : 1;
    else       size = (MemReadM == 2'd3) ? 4 : (MemReadM == 2'd2) ? 2 : 1;
    off   = int'(ALUOutM % 4);
    mis   = op && (ALUOutM % size != 0);
    req   = op && !mis;
    stall = req && !dmem_ready;
    we    = req && store;
    addr  = req ? (ALUOutM & 32'hFFFF_FFFC) : 32'h0;
    be_i  = store ? (int'(MemWriteM) << off) : (((1 << size) - 1) << off);
    be    = req ? be_i[3:0] : 4'h0;
    wdata = 32'h0;
    if (req && store)
      for (int i = 0; i < 4; i++) wdata[8*i +: 8] = WriteDataM[8*(i % size) +: 8];
    v    = 64'(dmem_rdata >> (8 * off));
    mask = (64'd1 << (8 * size)) - 64'd1;
    v    = v & mask;
    if (!LoadUnsignedM && size < 4 && v[8*size-1]) v = v | ~mask;
    rdw  = (load && !store && !mis) ? v[31:0] : 32'h0;
  endtask

  // Advance the model's MEM/WB image across one rising edge.
  task automatic model_clock();
    logic req, we, stall, mis;
    logic [3:0] be;
    logic [31:0] addr, wdata, rdw;
    model_comb(req, we, be, addr, wdata, stall, mis, rdw);
    e_mis = mis;
    if (stall) e_rw = 1'b0;
    else begin
      e_rw  = RegWriteM & !mis;
      e_mtr = MemtoRegM;
      e_rdw = rdw;
      e_alu = ALUOutM;
      e_wr  = WriteRegM;
    end
  endtask

  task automatic model_reset();
    e_rw = 0; e_mtr = 0; e_mis = 0; e_rdw = 0; e_alu = 0; e_wr = 0;
  endtask

  // One cycle with all outputs checked against the model. Inputs already set.
  task automatic model_cycle(output logic stall_o);
    logic req, we, stall, mis;
    logic [3:0] be;
    logic [31:0] addr, wdata, rdw;
    @(negedge clk);
    model_comb(req, we, be, addr, wdata, stall, mis, rdw);
    chk("rnd_req", 32'(dmem_req), 32'(req));
    chk("rnd_we", 32'(dmem_we), 32'(we));
    chk("rnd_be", 32'(dmem_be), 32'(be));
    chk("rnd_addr", dmem_addr, addr);
    chk("rnd_wdata", dmem_wdata, wdata);
    chk("rnd_stall", 32'(StallM), 32'(stall));
    model_clock();
    @(posedge clk); #1;
    chk("rnd_RegWriteW", 32'(RegWriteW), 32'(e_rw));
    chk("rnd_MemtoRegW", 32'(MemtoRegW), 32'(e_mtr));
    chk("rnd_ReadDataW", ReadDataW, e_rdw);
    chk("rnd_ALUOutW", ALUOutW, e_alu);
    chk("rnd_WriteRegW", 32'(WriteRegW), 32'(e_wr));
    chk("rnd_MisalignM", 32'(MisalignM), 32'(e_mis));
    stall_o = stall;
  endtask

  task automatic set_op(input logic [1:0] mr, input logic lu, input logic [3:0] mw,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wr);
    MemReadM = mr; LoadUnsignedM = lu; MemWriteM = mw;
    RegWriteM = 1'b1; MemtoRegM = (mr != 0);
    ALUOutM = addr; WriteDataM = wd; WriteRegM = wr;
  endtask

  task automatic set_nop();
    MemReadM = 0; LoadUnsignedM = 0; MemWriteM = 0; RegWriteM = 0; MemtoRegM = 0;
    ALUOutM = 0; WriteDataM = 0; WriteRegM = 0; dmem_rdata = 0; dmem_ready = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  mr;
    logic        lu;
    logic [3:0]  mw;
    logic [31:0] addr, wd, rd;
    logic        rdy;
    logic        x_req, x_we;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic        x_stall, x_rw;
    logic [31:0] x_rdw;
    logic        x_mis;
  } vec_t;

  vec_t tv[13];

  function automatic vec_t mk(logic [1:0] mr, logic lu, logic [3:0] mw, logic [31:0] addr,
                              logic [31:0] wd, logic [31:0] rd, logic rdy, logic x_req,
                              logic x_we, logic [3:0] x_be, logic [31:0] x_wdata,
                              logic x_stall, logic x_rw, logic [31:0] x_rdw, logic x_mis);
    vec_t v;
    v.mr = mr; v.lu = lu; v.mw = mw; v.addr = addr; v.wd = wd; v.rd = rd; v.rdy = rdy;
    v.x_req = x_req; v.x_we = x_we; v.x_be = x_be; v.x_wdata = x_wdata;
    v.x_stall = x_stall; v.x_rw = x_rw; v.x_rdw = x_rdw; v.x_mis = x_mis;
    return v;
  endfunction

  logic st_o;

  initial begin
    //          mr lu mw       addr          wd            rd            rdy req we be       wdata         stl rw rdw           mis
    tv[0]  = mk(3, 0, 4'b0000, 32'h100, 32'h0,        32'h8899AABB, 1, 1, 0, 4'b1111, 32'h0,        0, 1, 32'h8899AABB, 0);
    tv[1]  = mk(1, 0, 4'b0000, 32'h103, 32'h0,        32'h80FF1234, 1, 1, 0, 4'b1000, 32'h0,        0, 1, 32'hFFFFFF80, 0);
    tv[2]  = mk(1, 1, 4'b0000, 32'h103, 32'h0,        32'h80FF1234, 1, 1, 0, 4'b1000, 32'h0,        0, 1, 32'h00000080, 0);
    tv[3]  = mk(0, 0, 4'b0011, 32'h202, 32'h0000BEEF, 32'h0,        1, 1, 1, 4'b1100, 32'hBEEFBEEF, 0, 1, 32'h0,        0);
    tv[4]  = mk(3, 0, 4'b0000, 32'h101, 32'h0,        32'h12345678, 0, 0, 0, 4'b0000, 32'h0,        0, 0, 32'h0,        1);
    tv[5]  = mk(2, 0, 4'b0000, 32'h102, 32'h0,        32'h80FF1234, 1, 1, 0, 4'b1100, 32'h0,        0, 1, 32'hFFFF80FF, 0);
    tv[6]  = mk(2, 1, 4'b0000, 32'h100, 32'h0,        32'h80FF1234, 1, 1, 0, 4'b0011, 32'h0,        0, 1, 32'h00001234, 0);
    tv[7]  = mk(0, 0, 4'b0000, 32'h12345678, 32'h5555, 32'hFFFFFFFF, 0, 0, 0, 4'b0000, 32'h0,       0, 1, 32'h0,        0);
    tv[8]  = mk(3, 0, 4'b1111, 32'h010, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 1, 1, 4'b1111, 32'hCAFEF00D, 0, 1, 32'h0,        0);
    tv[9]  = mk(0, 0, 4'b0001, 32'h001, 32'h000000A5, 32'h0,        1, 1, 1, 4'b0010, 32'hA5A5A5A5, 0, 1, 32'h0,        0);
    tv[10] = mk(0, 0, 4'b1111, 32'h006, 32'h11112222, 32'h0,        1, 0, 0, 4'b0000, 32'h0,        0, 0, 32'h0,        1);
    tv[11] = mk(2, 0, 4'b0000, 32'h101, 32'h0,        32'h0,        1, 0, 0, 4'b0000, 32'h0,        0, 0, 32'h0,        1);
    tv[12] = mk(0, 0, 4'b0000, 32'h44, 32'h0,         32'h0,        1, 0, 0, 4'b0000, 32'h0,        0, 1, 32'h0,        0);

    // Reset state, including an active op presented during reset.
    inicio = 1'b0;
    set_nop();
    model_reset();
    #2;
    set_op(2'd3, 0, 4'b0000, 32'h100, 0, 5'd3);
    dmem_ready = 1'b0;
    #1;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(StallM), 0);
    chk("rst_be", 32'(dmem_be), 0);
    chk("rst_RegWriteW", 32'(RegWriteW), 0);
    chk("rst_ReadDataW", ReadDataW, 0);
    chk("rst_MisalignM", 32'(MisalignM), 0);
    @(negedge clk);
    set_nop();
    inicio = 1'b1;
    model_clock();
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      set_op(tv[i].mr, tv[i].lu, tv[i].mw, tv[i].addr, tv[i].wd, 5'(i + 1));
      dmem_rdata = tv[i].rd;
      dmem_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(tv[i].x_req));
      chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(tv[i].x_we));
      chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(tv[i].x_be));
      chk($sformatf("v%0d_wdata", i), dmem_wdata, tv[i].x_wdata);
      chk($sformatf("v%0d_addr", i), dmem_addr, tv[i].x_req ? (tv[i].addr & 32'hFFFFFFFC) : 32'h0);
      chk($sformatf("v%0d_stall", i), 32'(StallM), 32'(tv[i].x_stall));
      model_clock();
      @(posedge clk); #1;
      chk($sformatf("v%0d_RegWriteW", i), 32'(RegWriteW), 32'(tv[i].x_rw));
      chk($sformatf("v%0d_ReadDataW", i), ReadDataW, tv[i].x_rdw);
      chk($sformatf("v%0d_MisalignM", i), 32'(MisalignM), 32'(tv[i].x_mis));
      chk($sformatf("v%0d_ALUOutW", i), ALUOutW, tv[i].addr);
      chk($sformatf("v%0d_WriteRegW", i), 32'(WriteRegW), i + 1);
    end

    // Word load with ready delayed three cycles.
    set_op(2'd3, 0, 4'b0000, 32'h40, 0, 5'd7);
    dmem_ready = 1'b0;
    dmem_rdata = 32'hDEADDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dly_stall", 32'(StallM), 1);
      chk("dly_req", 32'(dmem_req), 1);
      chk("dly_addr", dmem_addr, 32'h40);
      model_clock();
      @(posedge clk); #1;
      chk("dly_bubble", 32'(RegWriteW), 0);
      chk("dly_hold_alu", ALUOutW, 32'h44);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11223344;
    @(negedge clk);
    chk("dly_done_stall", 32'(StallM), 0);
    model_clock();
    @(posedge clk); #1;
    chk("dly_RegWriteW", 32'(RegWriteW), 1);
    chk("dly_ReadDataW", ReadDataW, 32'h11223344);
    chk("dly_WriteRegW", 32'(WriteRegW), 7);

    // Reset asserted while waiting on memory.
    set_op(2'd3, 0, 4'b0000, 32'h80, 0, 5'd9);
    dmem_ready = 1'b0;
    @(negedge clk);
    chk("wrst_stall_before", 32'(StallM), 1);
    model_clock();
    @(posedge clk); #2;
    inicio = 1'b0;
    #1;
    chk("wrst_req", 32'(dmem_req), 0);
    chk("wrst_stall", 32'(StallM), 0);
    chk("wrst_ALUOutW", ALUOutW, 0);
    chk("wrst_WriteRegW", 32'(WriteRegW), 0);
    chk("wrst_RegWriteW", 32'(RegWriteW), 0);
    chk("wrst_MemtoRegW", 32'(MemtoRegW), 0);
    model_reset();
    set_nop();
    @(negedge clk);
    inicio = 1'b1;
    model_clock();
    @(posedge clk); #1;
    set_op(2'd3, 0, 4'b0000, 32'h84, 0, 5'd10);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hA5A50001;
    @(negedge clk);
    chk("post_req", 32'(dmem_req), 1);
    chk("post_stall", 32'(StallM), 0);
    model_clock();
    @(posedge clk); #1;
    chk("post_RegWriteW", 32'(RegWriteW), 1);
    chk("post_ReadDataW", ReadDataW, 32'hA5A50001);

    // Randomized traffic; EX/MEM inputs are held while the stage is stalled.
    st_o = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!st_o) begin
        int kind;
        logic [3:0] masks[3];
        masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b1111;
        kind = int'($urandom_range(0, 7));
        MemReadM  = 0;
        MemWriteM = 0;
        case (kind)
          1, 2, 3: MemReadM = 2'(kind);
          4, 5, 6: MemWriteM = masks[kind - 4];
          7: begin
            MemReadM  = 2'($urandom_range(1, 3));
            MemWriteM = masks[$urandom_range(0, 2)];
          end
          default: ;
        endcase
        LoadUnsignedM = 1'($urandom_range(0, 1));
        RegWriteM     = 1'($urandom_range(0, 1));
        MemtoRegM     = 1'($urandom_range(0, 1));
        ALUOutM       = $urandom & 32'h0000_0FFF;
        WriteDataM    = $urandom;
        WriteRegM     = 5'($urandom_range(0, 31));
      end
      dmem_rdata = $urandom;
      dmem_ready = ($urandom_range(0, 2) != 0);
      model_cycle(st_o);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
